// File: rtl/sm3_iter.sv
// sm3_iter: sequential SM3 compression engine.
// Accepts one pre-padded 512-bit block per valid/ready handshake, runs
// ROUNDS_PER_CYCLE rounds per clock, chains blocks across a message and
// presents the 256-bit digest over a second valid/ready handshake.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   blk_valid/blk_ready     block handshake; blk_data[511:480] = W0
//   blk_first/blk_last      message delimiters (both may be set)
//   dig_valid/dig_ready     digest handshake
//   digest                  [255:224] = A ... [31:0] = H
//   busy                    high whenever the engine is not idle
module sm3_iter #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] digest,
  output logic         busy
);

  localparam int unsigned R = ROUNDS_PER_CYCLE;

  generate
    if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_rounds
      $error("sm3_iter: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
  localparam logic [31:0]  T_LO = 32'h79cc4519;
  localparam logic [31:0]  T_HI = 32'h7a879d8a;
  localparam logic [6:0]   J_LAST = 7'(64 - R);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [255:0]   v_q;
  logic [255:0]   work_q, work_nxt;
  logic [511:0]   w_q, win_nxt;
  logic [6:0]     j_q;
  logic           last_q;
  logic           last_cyc;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
  endfunction

  function automatic logic [31:0] ff(input logic [31:0] x, y, z, input logic hi);
    return hi ? ((x & y) | (x & z) | (y & z)) : (x ^ y ^ z);
  endfunction

  function automatic logic [31:0] gg(input logic [31:0] x, y, z, input logic hi);
    return hi ? ((x & y) | (~x & z)) : (x ^ y ^ z);
  endfunction

  assign last_cyc = (j_q == J_LAST);

  // R unrolled rounds; the message window shifts one word per round so
  // W_j always sits in the top word and W_{j+16} enters at the bottom.
  always_comb begin
    logic [31:0]  a, b, c, d, e, f, g, h;
    logic [31:0]  a12, ss1, ss2, tt1, tt2, wj, wn;
    logic [511:0] win;
    logic [6:0]   jj;
    logic         hi;
    {a, b, c, d, e, f, g, h} = work_q;
    win = w_q;
    a12 = '0; ss1 = '0; ss2 = '0; tt1 = '0; tt2 = '0; wj = '0; wn = '0;
    jj  = '0; hi = 1'b0;
    for (int unsigned r = 0; r < R; r++) begin
      jj  = j_q + 7'(r);
      hi  = (jj >= 7'd16);
      wj  = win[511:480];
      wn  = p1(win[511:480] ^ win[287:256] ^ rotl(win[95:64], 5'd15))
            ^ rotl(win[415:384], 5'd7) ^ win[191:160];
      a12 = rotl(a, 5'd12);
      ss1 = rotl(a12 + e + rotl(hi ? T_HI : T_LO, jj[4:0]), 5'd7);
      ss2 = ss1 ^ a12;
      tt1 = ff(a, b, c, hi) + d + ss2 + (wj ^ win[383:352]);
      tt2 = gg(e, f, g, hi) + h + ss1 + wj;
      d = c;
      c = rotl(b, 5'd9);
      b = a;
      a = tt1;
      h = g;
      g = rotl(f, 5'd19);
      f = e;
      e = p0(tt2);
      win = {win[479:0], wn};
    end
    work_nxt = {a, b, c, d, e, f, g, h};
    win_nxt  = win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (blk_valid) state_nxt = RUN;
      RUN:     if (last_cyc)  state_nxt = last_q ? DONE : IDLE;
      DONE:    if (dig_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    blk_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= IV;
      work_q    <= '0;
      w_q       <= '0;
      j_q       <= '0;
      last_q    <= 1'b0;
      digest    <= '0;
      dig_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (blk_valid) begin
            w_q    <= blk_data;
            last_q <= blk_last;
            j_q    <= '0;
            if (blk_first) begin
              work_q <= IV;
              v_q    <= IV;
            end else begin
              work_q <= v_q;
            end
          end
        end
        RUN: begin
          work_q <= work_nxt;
          w_q    <= win_nxt;
          j_q    <= j_q + 7'(R);
          if (last_cyc) begin
            j_q <= '0;
            v_q <= v_q ^ work_nxt;
            if (last_q) begin
              digest    <= v_q ^ work_nxt;
              dig_valid <= 1'b1;
            end
          end
        end
        DONE: if (dig_ready) dig_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm3_iter.sv
module tb_sm3_iter;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] ABCD_B1   = {16{32'h61626364}};
  localparam logic [511:0] ABCD_B2   = {32'h80000000, 448'h0, 32'h00000200};
  localparam logic [511:0] JUNK_BLK  = {16{32'hdeadbeef}};
  localparam logic [255:0] ABC_DIG   = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [255:0] ABCD_DIG  = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
    logic [255:0] exp;
    int unsigned  hold;
    logic         junk;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  // R = 1 instance
  logic         blk_valid = 1'b0, blk_first = 1'b0, blk_last = 1'b0, dig_ready = 1'b0;
  logic [511:0] blk_data = '0;
  logic         blk_ready, dig_valid, busy;
  logic [255:0] digest;

  // R = 2, 4, 8, 16 instances sharing one input set
  logic         s_valid = 1'b0, s_first = 1'b0, s_last = 1'b0, s_dig_ready = 1'b0;
  logic [511:0] s_data = '0;
  logic [3:0]   sw_blk_ready, sw_dig_valid, sw_busy;
  logic [255:0] sw_digest [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sm3_iter #(.ROUNDS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .digest(digest), .busy(busy)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    sm3_iter #(.ROUNDS_PER_CYCLE(2 << gi)) u_sw (
      .clk(clk), .rst_n(rst_n),
      .blk_valid(s_valid), .blk_ready(sw_blk_ready[gi]), .blk_data(s_data),
      .blk_first(s_first), .blk_last(s_last),
      .dig_valid(sw_dig_valid[gi]), .dig_ready(s_dig_ready),
      .digest(sw_digest[gi]), .busy(sw_busy[gi])
    );
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  cnt;
    bit  rdy_hi;
    bit  stable;
    cnt = 0;
    while (!blk_ready && cnt < 200) begin tick(); cnt++; end
    chk({tag, " ready before accept"}, 256'(blk_ready), 256'(1));
    blk_valid = 1'b1; blk_data = v.data; blk_first = v.first; blk_last = v.last;
    tick();
    blk_valid = 1'b0; blk_data = '0;
    cnt = 0; rdy_hi = 1'b0;
    while (cnt < 200) begin
      if (v.junk && cnt == 10) begin
        blk_valid = 1'b1; blk_data = JUNK_BLK; blk_first = 1'b1; blk_last = 1'b0;
      end else begin
        blk_valid = 1'b0;
      end
      tick();
      cnt++;
      if (v.last ? dig_valid : blk_ready) break;
      if (blk_ready) rdy_hi = 1'b1;
    end
    blk_valid = 1'b0;
    chk({tag, " latency"}, 256'(cnt), 256'(64));
    if (v.last) begin
      chk({tag, " ready low in run"}, 256'(rdy_hi), 256'(0));
      chk({tag, " digest"}, digest, v.exp);
      stable = 1'b1;
      for (int unsigned h = 0; h < v.hold; h++) begin
        tick();
        if (digest !== v.exp || dig_valid !== 1'b1 || blk_ready !== 1'b0) stable = 1'b0;
      end
      if (v.hold != 0) chk({tag, " held under backpressure"}, 256'(stable), 256'(1));
      dig_ready = 1'b1;
      tick();
      dig_ready = 1'b0;
      chk({tag, " taken valid/ready"}, {254'(0), dig_valid, blk_ready}, 256'b01);
    end
  endtask

  task automatic sweep_blk(input logic [511:0] data, input logic first, input logic last,
                           input logic [255:0] exp, input string tag);
    int lat [4];
    bit seen [4];
    int cnt;
    for (int g = 0; g < 4; g++) begin lat[g] = 999; seen[g] = 1'b0; end
    s_valid = 1'b1; s_data = data; s_first = first; s_last = last;
    tick();
    s_valid = 1'b0; s_data = '0;
    cnt = 0;
    while (cnt < 100 && !(seen[0] && seen[1] && seen[2] && seen[3])) begin
      tick();
      cnt++;
      for (int g = 0; g < 4; g++)
        if (!seen[g] && (last ? sw_dig_valid[g] : sw_blk_ready[g])) begin
          seen[g] = 1'b1; lat[g] = cnt;
        end
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("%s R=%0d latency", tag, 2 << g), 256'(lat[g]), 256'(32 >> g));
      if (last) chk($sformatf("%s R=%0d digest", tag, 2 << g), sw_digest[g], exp);
    end
    if (last) begin
      s_dig_ready = 1'b1;
      tick();
      s_dig_ready = 1'b0;
      chk({tag, " all taken"}, {248'(0), sw_dig_valid, sw_blk_ready}, {248'(0), 4'b0000, 4'b1111});
    end
  endtask

  initial begin
    vec_t vecs [5];
    int   cnt;
    bit   never;

    vecs[0] = '{data: ABC_BLK, first: 1'b1, last: 1'b1, exp: ABC_DIG,  hold: 0,  junk: 1'b0};
    vecs[1] = '{data: ABCD_B1, first: 1'b1, last: 1'b0, exp: '0,       hold: 0,  junk: 1'b0};
    vecs[2] = '{data: ABCD_B2, first: 1'b0, last: 1'b1, exp: ABCD_DIG, hold: 10, junk: 1'b0};
    vecs[3] = '{data: ABC_BLK, first: 1'b1, last: 1'b1, exp: ABC_DIG,  hold: 0,  junk: 1'b1};
    vecs[4] = '{data: ABC_BLK, first: 1'b1, last: 1'b1, exp: ABC_DIG,  hold: 3,  junk: 1'b0};

    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk("reset dig_valid/busy", {254'(0), dig_valid, busy}, 256'(0));
    chk("reset digest", digest, 256'(0));
    chk("reset sweep dig_valid", 256'(sw_dig_valid), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ready after release", 256'(blk_ready), 256'(1));

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // reset during RUN cycle 30 aborts the message
    blk_valid = 1'b1; blk_data = ABC_BLK; blk_first = 1'b1; blk_last = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    chk("busy before abort", 256'(busy), 256'(1));
    rst_n = 1'b0;
    #2;
    chk("abort async outputs", {254'(0), dig_valid, busy}, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("abort ready after release", 256'(blk_ready), 256'(1));
    never = 1'b1;
    for (cnt = 0; cnt < 80; cnt++) begin
      tick();
      if (dig_valid) never = 1'b0;
    end
    chk("abort no digest", 256'(never), 256'(1));
    run_vec(vecs[0], "post-abort");

    // R = 2/4/8/16: single block then two-block message
    sweep_blk(ABC_BLK, 1'b1, 1'b1, ABC_DIG, "sweep abc");
    sweep_blk(ABCD_B1, 1'b1, 1'b0, '0, "sweep abcd b1");
    sweep_blk(ABCD_B2, 1'b0, 1'b1, ABCD_DIG, "sweep abcd b2");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sm3_iter.md
Name: sm3_iter

Overview:
- Sequential, parametrised SM3 compression engine; the clocked successor to the combinational multi-block sm3 chain.
- Accepts pre-padded 512-bit blocks one at a time over a valid/ready handshake and runs ROUNDS_PER_CYCLE rounds per clock.
- Chains blocks across a message and presents the 256-bit digest over a second valid/ready handshake.
- Sits between the padding/stream front end and any consumer of hash results; supports back-to-back messages.

Parameters:
- ROUNDS_PER_CYCLE, 1, SM3 rounds unrolled per clock. Legal values: 1, 2, 4, 8, 16; any other value is a static assertion error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- blk_valid  input  1  blk_data/blk_first/blk_last are valid.
- blk_ready  output  1  engine accepts a block this cycle.
- blk_data  input  512  padded block; [511:480] is W0, big-endian word order.
- blk_first  input  1  block starts a new message; chain from the IV.
- blk_last  input  1  block ends the message; produce a digest.
- dig_valid  output  1  digest is valid.
- dig_ready  input  1  consumer takes the digest.
- digest  output  256  hash result; [255:224] = A word, [31:0] = H word.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous release by the clock):
  - state = IDLE, chaining register V = IV (7380166F 4914B2B9 172442D7 DA8A0600 A96F30BC 163138AA E38DEE4D B0FB0E4E).
  - digest = 0, dig_valid = 0, busy = 0, round counter = 0.
  - blk_ready = 1 from the first cycle after release.
- State IDLE:
  - blk_ready = 1.
  - On blk_valid & blk_ready: latch the 16 message words into a 16-word window and latch the last flag.
  - Working registers A..H load IV if blk_first = 1, else V. If blk_first = 1, V also loads IV.
  - Go to RUN with counter j = 0.
- State RUN:
  - blk_ready = 0.
  - Each cycle performs ROUNDS_PER_CYCLE consecutive rounds j..j+R-1, then j += R.
  - Expansion is computed on the fly: W' = W_j ^ W_{j+4}; new W_{j+16} = P1(W_j ^ W_{j+7} ^ rotl(W_{j+13},15)) ^ rotl(W_{j+3},7) ^ W_{j+10}; the window shifts by R words per cycle.
  - Round constant: T = 79CC4519 for j < 16, else 7A879D8A, rotated left by (j mod 32).
  - FF/GG use XOR for j < 16 and majority/choose for j >= 16. P0(x) = x ^ rotl9 ^ rotl17.
  - All additions are mod 2^32.
  - N = 64/ROUNDS_PER_CYCLE cycles in RUN. On the N-th edge, V <= V ^ {A..H after round 63}, computed in the same edge.
  - Exit: if the last flag is set, digest <= new V, dig_valid <= 1, go to DONE. Otherwise go to IDLE.
- State DONE:
  - dig_valid = 1 and digest is held stable while dig_ready = 0.
  - On dig_ready: dig_valid <= 0, go to IDLE.
  - V is kept, so a following block with blk_first = 0 continues the chain. This is defined behaviour, not an error.
- Latency:
  - Acceptance edge T0; the digest is visible after edge T0+N.
  - N = 64 at R = 1, 16 at R = 4.
  - Block throughput is one block per N+1 cycles (one IDLE cycle between blocks).
- blk_first and blk_last may both be 1 for a single-block message.
- blk_data, blk_first and blk_last are ignored when blk_ready = 0; no buffering.
- Reset mid-RUN or mid-DONE aborts immediately: the partial chain is discarded, dig_valid drops asynchronously, and no digest is emitted.
- No padding is done here; input blocks are already SM3-padded.

Test Plan:
- "abc" single padded block (blk_first = blk_last = 1), R = 1 -> digest 66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0, and dig_valid rises exactly 64 cycles after acceptance.
- "abcd"x16 as two padded blocks (first, then last), R = 4 -> debe9ff9 2275b8a1 38604889 c18e5a4d 6fdb70e5 387e5765 293dcba3 9c0c5732; each block takes 16 RUN cycles and blk_ready is low throughout.
- Back-pressure: hold dig_ready = 0 for 10 cycles -> digest stable, dig_valid stays 1, blk_ready = 0; the digest is taken on the cycle dig_ready rises and blk_ready = 1 on the next cycle.
- Back-to-back messages: "abc" then "abc" again with blk_first = 1 -> both digests equal the "abc" value (IV restart verified).
- Reset pulse at RUN cycle 30 -> dig_valid never asserts and blk_ready = 1 after release; a subsequent "abc" yields the correct digest.
- blk_valid asserted during RUN with a junk block -> the junk is ignored and the in-flight digest is unchanged.
- Parameter sweep R in {1, 2, 8, 16} on "abc" -> identical digest, with latencies 64, 32, 8 and 4 cycles.
